// File: rtl/result_rf.sv
// Result buffer at the bottom edge of the 8x8 systolic array: captures eight drained rows,
// then holds them for host readback until the host releases ownership.
module result_rf #(
    parameter int DATA_W = 16
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   START,
    input  logic                   IN_VALID,
    input  logic [0:7][DATA_W-1:0] ROW_IN,
    input  logic                   RF_READ,
    input  logic [31:0]            ADDR,
    input  logic                   RELEASE,
    output logic [DATA_W-1:0]      DOUT,
    output logic                   DOUT_VALID,
    output logic                   RD_ERR,
    output logic                   BUSY,
    output logic                   DONE,
    output logic                   OVF,
    output logic [1:0]             STATE_DBG
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         row_cnt;
    logic [DATA_W-1:0]  out_seq [0:7][0:7];
    logic               rd_ok;

    // Handshake: IN_VALID and RF_READ are accepted on the edge they are high (no ready,
    // no backpressure); each RF_READ yields exactly one pulse next cycle, DOUT_VALID or RD_ERR.
    assign rd_ok     = RF_READ && (state == S_HOLD) && (ADDR[31:6] == 26'd0);
    assign BUSY      = (state == S_FILL);
    assign DONE      = (state == S_HOLD);
    assign STATE_DBG = state;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= S_IDLE;
            row_cnt    <= 3'd0;
            DOUT       <= '0;
            DOUT_VALID <= 1'b0;
            RD_ERR     <= 1'b0;
            OVF        <= 1'b0;
            for (int r = 0; r < 8; r++) begin
                for (int c = 0; c < 8; c++) begin
                    out_seq[r][c] <= '0;
                end
            end
        end else begin
            DOUT_VALID <= rd_ok;
            RD_ERR     <= RF_READ && !rd_ok;
            if (rd_ok) begin
                DOUT <= out_seq[ADDR[5:3]][ADDR[2:0]];
            end

            case (state)
                S_IDLE: begin
                    if (START) begin
                        state   <= S_FILL;
                        row_cnt <= 3'd0;
                        OVF     <= 1'b0;
                    end else if (IN_VALID) begin
                        OVF <= 1'b1;
                    end
                end
                S_FILL: begin
                    // An abort restarts the row count; the coincident beat is dropped.
                    if (START) begin
                        row_cnt <= 3'd0;
                    end else if (IN_VALID) begin
                        for (int c = 0; c < 8; c++) begin
                            out_seq[row_cnt][c] <= ROW_IN[c];
                        end
                        row_cnt <= row_cnt + 3'd1;
                        if (row_cnt == 3'd7) begin
                            state <= S_HOLD;
                        end
                    end
                end
                S_HOLD: begin
                    if (IN_VALID) begin
                        OVF <= 1'b1;
                    end
                    if (RELEASE) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_result_rf.sv
// Directed bench for result_rf: drivers push expected read responses into a queue,
// a negedge monitor pops and compares whenever DOUT_VALID or RD_ERR is presented.
module tb_result_rf;

    localparam int DATA_W = 16;

    logic                   CLK;
    logic                   RST_N;
    logic                   START;
    logic                   IN_VALID;
    logic [0:7][DATA_W-1:0] ROW_IN;
    logic                   RF_READ;
    logic [31:0]            ADDR;
    logic                   RELEASE;
    logic [DATA_W-1:0]      DOUT;
    logic                   DOUT_VALID;
    logic                   RD_ERR;
    logic                   BUSY;
    logic                   DONE;
    logic                   OVF;
    logic [1:0]             STATE_DBG;

    int total = 0;
    int bad   = 0;

    // Expected response: MSB = read rejected, low bits = DOUT.
    logic [DATA_W:0]   exp_q[$];
    logic [DATA_W-1:0] exp_mem [64];
    logic [DATA_W-1:0] last_dout;

    result_rf #(.DATA_W(DATA_W)) dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .START      (START),
        .IN_VALID   (IN_VALID),
        .ROW_IN     (ROW_IN),
        .RF_READ    (RF_READ),
        .ADDR       (ADDR),
        .RELEASE    (RELEASE),
        .DOUT       (DOUT),
        .DOUT_VALID (DOUT_VALID),
        .RD_ERR     (RD_ERR),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .OVF        (OVF),
        .STATE_DBG  (STATE_DBG)
    );

    // Clock / reset
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached (bad=%0d)", bad);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge CLK) begin
        if (RST_N && (DOUT_VALID || RD_ERR)) begin
            logic [DATA_W:0] exp;
            chk("rd_exclusive", {31'd0, DOUT_VALID && RD_ERR}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("rd_unexpected", {15'd0, RD_ERR, DOUT}, 32'hFFFF_FFFF);
            end else begin
                exp = exp_q.pop_front();
                chk("rd_resp", {15'd0, RD_ERR, DOUT}, {15'd0, exp});
            end
        end
    end

    // Driver tasks
    task automatic pulse_start();
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic pulse_release();
        RELEASE = 1'b1;
        @(negedge CLK);
        RELEASE = 1'b0;
    endtask

    task automatic beat(input logic [DATA_W-1:0] base, input int r);
        for (int c = 0; c < 8; c++) begin
            ROW_IN[c] = base + DATA_W'(c);
            exp_mem[r*8 + c] = base + DATA_W'(c);
        end
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input bit ok, input bit rel);
        RF_READ = 1'b1;
        ADDR    = a;
        RELEASE = rel;
        if (ok) last_dout = exp_mem[a[5:0]];
        exp_q.push_back({ok ? 1'b0 : 1'b1, last_dout});
        @(negedge CLK);
        RF_READ = 1'b0;
        RELEASE = 1'b0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 64; a++) begin
            rd(32'(a), 1'b1, 1'b0);
        end
    endtask

    initial begin
        RST_N = 1'b0; START = 1'b0; IN_VALID = 1'b0; ROW_IN = '0;
        RF_READ = 1'b0; ADDR = '0; RELEASE = 1'b0; last_dout = '0;
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;

        // Reset state and idle behaviour
        @(negedge CLK);
        @(negedge CLK);
        chk("reset_outputs", {11'd0, DOUT, DOUT_VALID, RD_ERR, BUSY, DONE, OVF}, 32'd0);
        RST_N = 1'b1;
        rd(32'd5, 1'b0, 1'b0);
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("ovf_idle_beat", {31'd0, OVF}, 32'd1);

        // Full capture with continuous beats
        pulse_start();
        chk("busy_after_start", {30'd0, BUSY, DONE}, 32'd2);
        chk("ovf_cleared_by_start", {31'd0, OVF}, 32'd0);
        for (int r = 0; r < 8; r++) begin
            beat(DATA_W'(16'h0100 * r), r);
            if (r == 6) chk("done_before_last_beat", {31'd0, DONE}, 32'd0);
        end
        chk("done_after_capture", {30'd0, BUSY, DONE}, 32'd1);
        read_all();

        // Address range and ownership hand-back
        rd(32'h40, 1'b0, 1'b0);
        rd(32'h8000_0009, 1'b0, 1'b0);
        rd(32'd9, 1'b1, 1'b1);
        chk("done_low_after_release", {30'd0, BUSY, DONE}, 32'd0);
        rd(32'd3, 1'b0, 1'b0);

        // Stalled capture: IN_VALID toggles 1,0,1,0...
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                beat(DATA_W'(16'hA000 + 16'h0010 * (i / 2)), i / 2);
            end else begin
                @(negedge CLK);
            end
            if (i == 13) chk("stall_not_done", {30'd0, BUSY, DONE}, 32'd2);
            if (i == 14) chk("stall_done", {30'd0, BUSY, DONE}, 32'd1);
        end
        read_all();
        pulse_release();

        // Abort mid-capture, then overflow in HOLD
        pulse_start();
        for (int r = 0; r < 3; r++) beat(16'h1111, r);
        for (int c = 0; c < 8; c++) ROW_IN[c] = 16'h2222;
        START = 1'b1;
        IN_VALID = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        IN_VALID = 1'b0;
        chk("abort_stays_fill", {30'd0, BUSY, DONE}, 32'd2);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) ROW_IN[c] = 16'hBEEF;
            for (int c = 0; c < 8; c++) exp_mem[r*8 + c] = 16'hBEEF;
            IN_VALID = 1'b1;
            @(negedge CLK);
        end
        IN_VALID = 1'b0;
        chk("abort_done", {30'd0, BUSY, DONE}, 32'd1);
        chk("abort_no_ovf", {31'd0, OVF}, 32'd0);
        for (int c = 0; c < 8; c++) ROW_IN[c] = 16'h5555;
        IN_VALID = 1'b1;
        @(negedge CLK);
        IN_VALID = 1'b0;
        chk("ovf_hold_beat", {31'd0, OVF}, 32'd1);
        pulse_start();
        chk("start_ignored_in_hold", {29'd0, OVF, BUSY, DONE}, 32'd5);
        read_all();
        pulse_release();
        chk("ovf_sticky_after_release", {29'd0, OVF, BUSY, DONE}, 32'd4);

        // Asynchronous reset mid-capture
        pulse_start();
        chk("ovf_cleared_again", {31'd0, OVF}, 32'd0);
        for (int r = 0; r < 4; r++) beat(16'h7777, r);
        #2;
        RST_N = 1'b0;
        #1;
        chk("async_reset_outputs", {11'd0, DOUT, DOUT_VALID, RD_ERR, BUSY, DONE, OVF}, 32'd0);
        chk("async_reset_state", {30'd0, STATE_DBG}, 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        last_dout = '0;
        pulse_start();
        for (int r = 0; r < 8; r++) beat(16'h0000, r);
        chk("post_reset_done", {30'd0, BUSY, DONE}, 32'd1);
        read_all();
        pulse_release();

        repeat (3) @(negedge CLK);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/result_rf.md
# result_rf

Result register file at the output edge of the 8x8 systolic array. It captures the eight result rows drained from the bottom of the array, one row per beat, into a 64-entry buffer. The host then reads the buffer back over the same ADDR word indexing the host uses to load input sequences. Buffer ownership is handed between array and host by a three-state controller, so the host never reads a partially filled matrix.

## Interface
- DATA_W, 16, width of one result element (N fixed at 8; buffer 8x8)
- CLK  input  1  rising-edge clock
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  pulse; arms capture of a new result matrix
- IN_VALID  input  1  ROW_IN carries one result row this cycle
- ROW_IN  input  DATA_W x [0:7]  result row, element c = column c
- RF_READ  input  1  host read request this cycle
- ADDR  input  32  element index; row = ADDR[5:3], col = ADDR[2:0]
- RELEASE  input  1  pulse; host is done, returns buffer to IDLE
- DOUT  output  DATA_W  read data
- DOUT_VALID  output  1  DOUT valid (one-cycle pulse per accepted read)
- RD_ERR  output  1  one-cycle pulse: read rejected
- BUSY  output  1  state == FILL
- DONE  output  1  state == HOLD (matrix complete, readable)
- OVF  output  1  sticky: IN_VALID seen outside FILL

## Operation
- Storage: OUT_SEQ[0:7][0:7] of DATA_W; row counter row_cnt (3 bits); state in {IDLE, FILL, HOLD}.
- IDLE: START -> FILL, row_cnt <= 0, OVF <= 0. IN_VALID without START -> OVF <= 1, data discarded.
- FILL: IN_VALID -> OUT_SEQ[row_cnt][c] <= ROW_IN[c] for all c, row_cnt++. IN_VALID low -> stall, no write. The beat with row_cnt == 7 moves to HOLD. START in FILL aborts: row_cnt <= 0, the same-cycle IN_VALID beat is discarded, and the state stays FILL. Rows already written are not cleared; they are overwritten by the new capture.
- HOLD: buffer is frozen. IN_VALID -> OVF <= 1, no write. START is ignored. RELEASE -> IDLE.
- Read: RF_READ accepted only when state == HOLD and ADDR[31:6] == 0. An accepted read gives DOUT <= OUT_SEQ[ADDR[5:3]][ADDR[2:0]] and DOUT_VALID pulses next cycle.
- Rejected read (state != HOLD or ADDR[31:6] != 0): RD_ERR pulses next cycle, DOUT_VALID = 0, DOUT holds its previous value.
- RF_READ and RELEASE in the same HOLD cycle: the read is accepted and served, and the state goes to IDLE.
- Back-to-back reads are allowed at one per cycle. There is no backpressure on DOUT.
- No arithmetic; elements are stored bit-exact.

## Timing
- Reset (RST_N low, asynchronous): state IDLE, row_cnt 0, OUT_SEQ all 0, DOUT 0, DOUT_VALID 0, RD_ERR 0, BUSY 0, DONE 0, OVF 0.
- Reset release: the first active edge is the first CLK rise with RST_N high.
- Reset mid-FILL or mid-HOLD discards the matrix; OUT_SEQ reads 0 after the next capture arms.
- START to BUSY: 1 cycle (registered state).
- Capture: with continuous IN_VALID, 8 cycles from the first beat; DONE rises on the cycle after the 8th beat.
- Read latency: 1 cycle, ADDR sampled at the RF_READ edge.
- RELEASE to DONE low: 1 cycle. The next START is accepted in the cycle after that.
- BUSY and DONE are decoded from registered state; they are never both 1.
- OVF is set on the cycle after the offending beat. It clears only on an accepted START (IDLE->FILL) or on reset.

## Test plan
- Reset/idle: assert RST_N=0 mid-cycle -> all outputs 0 immediately. RF_READ ADDR=5 in IDLE -> RD_ERR=1 next cycle, DOUT_VALID=0, DOUT=0.
- Full capture and readback: START, then 8 consecutive beats with ROW_IN[c] = 16'h0100*r + c. DONE=1 after the 8th beat. Read ADDR 0..63 back-to-back -> DOUT = 16'h0100*(ADDR>>3) + (ADDR&7), DOUT_VALID high for 64 cycles.
- Stalled capture: START, beats with IN_VALID toggling 1,0,1,0... -> DONE after the 8th valid beat (cycle 16). Data matches the beat order, with no duplicate or skipped rows.
- Abort and overflow: START, 3 beats, then START+IN_VALID together, then 8 beats of 16'hBEEF -> all 64 reads 16'hBEEF. An extra IN_VALID in HOLD -> OVF=1 and the buffer is unchanged.
- Address/ownership: in HOLD, RF_READ with ADDR=32'h40 -> RD_ERR. RF_READ ADDR=9 together with RELEASE -> DOUT = element [1][1] with DOUT_VALID, then DONE=0. A following read -> RD_ERR.
- Reset mid-FILL after 4 beats -> IDLE and OVF=0. A new START plus 8 beats of 0 -> all reads 0.
